// File: rtl/qa_drv_hc_rx_demarshal_pkg.sv
// Shared types and constants for the host-to-FPGA line demarshaller.
// The message header layout is also used by clients that build header chunks.
package qa_drv_hc_rx_demarshal_pkg;

    localparam int CCI_CLDATA_WIDTH      = 512;
    localparam int QA_DRV_HC_RX_LEN_BITS = 16;
    localparam int QA_DRV_HC_RX_HDR_BITS = 64;
    localparam int QA_DRV_HC_RX_TAG_BITS = QA_DRV_HC_RX_HDR_BITS - 1 - QA_DRV_HC_RX_LEN_BITS;

    typedef struct packed {
        logic                             valid;
        logic [QA_DRV_HC_RX_TAG_BITS-1:0] tag;
        logic [QA_DRV_HC_RX_LEN_BITS-1:0] len;
    } t_qa_drv_hc_rx_msg_hdr;

    typedef enum logic {
        ST_HDR = 1'b0,
        ST_PAY = 1'b1
    } t_rx_state;

endpackage

// File: rtl/qa_drv_hc_rx_demarshal_if.sv
// Line-in / chunk-out bus of the demarshaller. The block takes the slave view;
// whoever feeds lines and drains chunks takes the master view.
interface qa_drv_hc_rx_demarshal_if #(
    parameter int N_CHUNK_BITS = 64
);
    import qa_drv_hc_rx_demarshal_pkg::*;

    logic [CCI_CLDATA_WIDTH-1:0] rx_data;
    logic                        rx_rdy;
    logic                        rx_enable;

    logic [N_CHUNK_BITS-1:0]     out_data;
    logic                        out_sop;
    logic                        out_eop;
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  rx_data, rx_rdy, out_ready,
        output rx_enable, out_data, out_sop, out_eop, out_valid
    );

    modport master (
        output rx_data, rx_rdy, out_ready,
        input  rx_enable, out_data, out_sop, out_eop, out_valid
    );

endinterface

// File: rtl/qa_drv_hc_rx_demarshal_fifo2.sv
// Two-entry FIFO with registered outputs; full throughput when one entry stays
// occupied and enqueue/dequeue coincide.
module cci_mpf_prim_fifo2 #(
    parameter int N_DATA_BITS = 32
)(
    input  logic                   clk,
    input  logic                   reset,

    input  logic [N_DATA_BITS-1:0] enq_data,
    input  logic                   enq_en,
    output logic                   notFull,

    output logic [N_DATA_BITS-1:0] first,
    input  logic                   deq_en,
    output logic                   notEmpty
);

    logic [N_DATA_BITS-1:0] data0_q, data1_q;
    logic                   valid0_q, valid1_q;
    logic                   deq;

    // Dequeue requests against an empty FIFO are ignored.
    assign deq      = deq_en && valid0_q;
    assign notFull  = !valid1_q;
    assign notEmpty = valid0_q;
    assign first    = data0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data0_q  <= '0;
            data1_q  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            case ({enq_en, deq})
                2'b10: begin
                    if (!valid0_q) begin
                        data0_q  <= enq_data;
                        valid0_q <= 1'b1;
                    end else begin
                        data1_q  <= enq_data;
                        valid1_q <= 1'b1;
                    end
                end
                2'b01: begin
                    data0_q  <= data1_q;
                    valid0_q <= valid1_q;
                    valid1_q <= 1'b0;
                end
                2'b11: begin
                    if (valid1_q) begin
                        data0_q <= data1_q;
                        data1_q <= enq_data;
                    end else begin
                        data0_q <= enq_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/qa_drv_hc_rx_demarshal.sv
// Splits host cache lines into framed chunk messages (header + len payload
// chunks); an invalid header chunk pads out the rest of its line.
module qa_drv_hc_rx_demarshal
    import qa_drv_hc_rx_demarshal_pkg::*;
#(
    parameter int N_CHUNK_BITS = 64
)(
    input  logic                    clk,
    input  logic                    reset,
    qa_drv_hc_rx_demarshal_if.slave bus,
    output logic [31:0]             msg_count
);

    localparam int N_CHUNKS = CCI_CLDATA_WIDTH / N_CHUNK_BITS;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int QW       = N_CHUNK_BITS + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    logic [N_CHUNKS-1:0][N_CHUNK_BITS-1:0] line_q, line_d;
    logic                                  line_valid_q, line_valid_d;
    logic [IDX_W-1:0]                      chunk_idx_q, chunk_idx_d;
    t_rx_state                             state_q;
    logic [QA_DRV_HC_RX_LEN_BITS-1:0]      remaining_q;
    logic [31:0]                           msg_count_q;

    logic [N_CHUNK_BITS-1:0]               cur_chunk;
    logic                                  hdr_valid;
    logic [QA_DRV_HC_RX_LEN_BITS-1:0]      hdr_len;
    logic                                  consume, is_pad, enq, line_done, load;
    logic                                  enq_sop, enq_eop;

    logic                                  q_not_full, q_not_empty;
    logic [QW-1:0]                         q_first;

    always_comb begin
        cur_chunk = line_q[chunk_idx_q];
        hdr_valid = cur_chunk[N_CHUNK_BITS-1];
        hdr_len   = cur_chunk[QA_DRV_HC_RX_LEN_BITS-1:0];
        consume   = line_valid_q && q_not_full;
        is_pad    = consume && (state_q == ST_HDR) && !hdr_valid;
        enq       = consume && !is_pad;
        enq_sop   = (state_q == ST_HDR);
        enq_eop   = (state_q == ST_HDR) ? (hdr_len == '0)
                                        : (remaining_q == QA_DRV_HC_RX_LEN_BITS'(1));
        line_done = is_pad || (consume && (chunk_idx_q == LAST_IDX));
        load      = !reset && bus.rx_rdy && (!line_valid_q || line_done);
    end

    assign bus.rx_enable = load;

    // A new line loaded in the same cycle the old one finishes takes priority.
    always_comb begin
        line_d       = line_q;
        line_valid_d = line_valid_q;
        chunk_idx_d  = chunk_idx_q;
        if (is_pad) begin
            line_valid_d = 1'b0;
            chunk_idx_d  = '0;
        end else if (consume) begin
            chunk_idx_d = chunk_idx_q + 1'b1;
            if (chunk_idx_q == LAST_IDX) line_valid_d = 1'b0;
        end
        if (load) begin
            line_d       = bus.rx_data;
            line_valid_d = 1'b1;
            chunk_idx_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q       <= '0;
            line_valid_q <= 1'b0;
            chunk_idx_q  <= '0;
        end else begin
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
            chunk_idx_q  <= chunk_idx_d;
        end
    end

    // Message framing; state carries across line boundaries and idle upstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HDR;
            remaining_q <= '0;
        end else if (enq) begin
            case (state_q)
                ST_HDR: begin
                    if (hdr_len != '0) begin
                        remaining_q <= hdr_len;
                        state_q     <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    remaining_q <= remaining_q - 1'b1;
                    if (remaining_q == QA_DRV_HC_RX_LEN_BITS'(1)) state_q <= ST_HDR;
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

    cci_mpf_prim_fifo2 #(
        .N_DATA_BITS (QW)
    ) out_q (
        .clk      (clk),
        .reset    (reset),
        .enq_data ({enq_sop, enq_eop, cur_chunk}),
        .enq_en   (enq),
        .notFull  (q_not_full),
        .first    (q_first),
        .deq_en   (bus.out_ready),
        .notEmpty (q_not_empty)
    );

    assign bus.out_valid = q_not_empty;
    assign bus.out_sop   = q_first[QW-1];
    assign bus.out_eop   = q_first[QW-2];
    assign bus.out_data  = q_first[N_CHUNK_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_count_q <= '0;
        end else if (q_not_empty && bus.out_ready && q_first[QW-2]) begin
            msg_count_q <= msg_count_q + 32'd1;
        end
    end

    assign msg_count = msg_count_q;

endmodule

// File: doc/qa_drv_hc_rx_demarshal.md
# qa_drv_hc_rx_demarshal

Splits the host-to-FPGA cache-line stream into framed messages of `N_CHUNK_BITS`-bit chunks for the FPGA-side client.
- Consumes the dequeue-style line interface (`rx_data`/`rx_rdy`/`rx_enable`) produced by the FIFO-from-host channel.
- Parses the per-message header chunk and emits header and payload chunks on a valid/ready stream marked with start/end of message.
- Messages may span line boundaries. An all-invalid header pads out the remainder of a line.

## Interface
- `N_CHUNK_BITS`, 64, width of one chunk. Must divide `CCI_CLDATA_WIDTH` (512) exactly.
- `N_CHUNKS`, `CCI_CLDATA_WIDTH/N_CHUNK_BITS`, chunks per line; derived, not overridable.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  512  head line from the FIFO-from-host channel.
- `rx_rdy`  in  1  `rx_data` valid.
- `rx_enable`  out  1  dequeue the head line this cycle.
- `out_data`  out  `N_CHUNK_BITS`  current chunk.
- `out_sop`  out  1  chunk is a message header.
- `out_eop`  out  1  chunk is the last chunk of its message.
- `out_valid`  out  1  chunk valid.
- `out_ready`  in  1  client accepts the chunk (a transfer occurs when `out_valid && out_ready`).
- `msg_count`  out  32  number of messages completed, counted on eop transfers; wraps.

## Operation
- **Line buffer**
  - One 512-bit register `line`, with flag `line_valid` and chunk index `chunk_idx` (`$clog2(N_CHUNKS)` bits).
  - Chunk k is `line[k*N_CHUNK_BITS +: N_CHUNK_BITS]`, so chunk 0 is the least significant.
- **Header chunk fields**
  - bit 63: valid.
  - bits [62:16]: tag, passed through untouched.
  - bits [15:0]: `len`, the number of payload chunks, 0..65535.
- **State machine**
  - HDR: expecting a header.
  - PAY: `remaining` (16 bits) payload chunks are outstanding.
- **Chunk consume.** A chunk is consumed when `line_valid` and the output queue is not full.
  - HDR, valid bit = 1: emit the chunk with sop=1 and eop=(`len`==0). If `len`≠0, load `remaining`=`len` and go to PAY.
  - HDR, valid bit = 0: pad. Emit nothing and drop the rest of the line: `line_valid`←0, `chunk_idx`←0. Stay in HDR.
  - PAY: emit with sop=0 and eop=(`remaining`==1), then decrement `remaining`. When it reaches 0, go to HDR.
- **Chunk index.** `chunk_idx` increments on every consume. A consume at `N_CHUNKS-1` wraps it to 0 and clears `line_valid`. The message state carries across the line boundary.
- **Line dequeue.** `rx_enable` = `!reset && rx_rdy && (!line_valid || line_done)`.
  - `line_done` means the last chunk or a pad is consumed this cycle.
  - When `rx_enable` is high, `line`←`rx_data`, `line_valid`←1, `chunk_idx`←0.
  - This allows back-to-back lines with no bubble.
- `msg_count` increments on every output transfer with eop=1.

## Timing
- **Reset values:** `rx_enable`=0, `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_data`=0, `msg_count`=0, state=HDR, `line_valid`=0, `remaining`=0.
- **Latency.** For a line dequeued in cycle t:
  - its chunk 0 is consumed in t+1;
  - it appears on `out_valid` in t+2.
- Sustained throughput is 1 chunk per cycle while `out_ready`=1.
- **Handshake.** `out_data`/`out_sop`/`out_eop` stay stable while `out_valid && !out_ready`. No chunk is dropped or duplicated under any backpressure pattern.
- **Empty upstream mid-message.** PAY holds with no output until the next line arrives.
- Reset asserted mid-message discards the buffered line and the partial message, and returns all state to reset values.
- **Simultaneous events** in one cycle:
  - last-chunk consume plus new line load: the load wins for `line_valid`;
  - eop transfer plus any consume: both take effect.

## Structure
- The header typedef `t_qa_drv_hc_rx_msg_hdr` (valid, tag, len) and the constant `QA_DRV_HC_RX_LEN_BITS=16` go in the shared `qa_drv_hc` package header.
- Output queue sub-module: `cci_mpf_prim_fifo2`, `N_DATA_BITS=N_CHUNK_BITS+2`.
  - Enqueue = chunk consume.
  - `out_valid` = its `notEmpty`; dequeue = `out_ready`.
- Whole block is about 200 lines of RTL.

## Test plan
- **Single-line message.** One line: header valid with `len`=3, three payload chunks, then pad.
  - Expect 4 output beats: sop on beat 0, eop on beat 3.
  - `msg_count`=1.
  - Exactly one line dequeued; the next line is requested after the pad.
- **Message spanning lines.** Header with `len`=10 at chunk 6.
  - Expect 11 beats across 3 lines with data in order.
  - eop only on the 10th payload chunk.
- **Header-only message.** `len`=0.
  - Expect one beat with sop=1 and eop=1.
  - The next chunk is parsed as a header.
- **Random backpressure.** `out_ready` toggles randomly (50%) over 1000 random messages.
  - Output chunk sequence bit-exact with the reference model.
  - No extra dequeues.
- **Idle gap mid-message.** `rx_rdy` drops mid-PAY for 20 cycles.
  - No output and no `rx_enable` during the gap.
  - Resumes correctly afterwards.
- **Reset mid-message.**
  - All outputs return to reset values the cycle after reset.
  - The first valid header after reset yields sop.
